// File: rtl/freq_analyzer_pkg.sv
// Shared state encodings and default widths for the frequency window analyzer.
package freq_analyzer_pkg;

    localparam int DEF_COUNT_WIDTH  = 32;
    localparam int DEF_WINDOW_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01
    } state_t;

endpackage

// File: rtl/sync_rise_detector.sv
// Synchroniser chain (STAGES flops, 0 = already synchronous) plus history flop; rise is a 1-cycle pulse.
// Every flop holds while enable is low; synchronous active-low reset clears the chain and history.
module sync_rise_detector #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic din,
    output logic rise
);

    logic level;
    logic hist;

    generate
        if (STAGES == 0) begin : g_direct
            assign level = din;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    sync_q <= '0;
                end else if (enable) begin
                    sync_q[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign level = sync_q[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist <= 1'b0;
        end else if (enable) begin
            hist <= level;
        end
    end

    assign rise = level & ~hist;

endmodule

// File: rtl/frequency_window_analyzer.sv
// Counts signal_in rising edges between start/stop rising edges; result_valid one clock after stop is sampled.
// No backpressure: results are overwritten by the next window, enable low freezes all state.
module frequency_window_analyzer
    import freq_analyzer_pkg::*;
#(
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
    parameter int WINDOW_WIDTH     = DEF_WINDOW_WIDTH,
    parameter int MAX_WINDOW_TICKS = 100000,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start_analyzer,
    input  logic                    stop_analyzer,
    input  logic                    signal_in,
    output logic [COUNT_WIDTH-1:0]  edge_count,
    output logic [WINDOW_WIDTH-1:0] window_ticks,
    output logic                    result_valid,
    output logic                    overflow,
    output logic                    timeout,
    output logic                    busy
);

    localparam logic [WINDOW_WIDTH-1:0] MAX_TICKS = WINDOW_WIDTH'(MAX_WINDOW_TICKS);

    logic start_rise;
    logic stop_rise;
    logic sig_rise;

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  live_cnt;
    logic [WINDOW_WIDTH-1:0] live_ticks;
    logic                    live_ovf;

    logic [COUNT_WIDTH-1:0]  cnt_next;
    logic [WINDOW_WIDTH-1:0] ticks_next;
    logic                    ovf_next;

    sync_rise_detector #(.STAGES(0)) u_start_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .din    (start_analyzer),
        .rise   (start_rise)
    );

    sync_rise_detector #(.STAGES(0)) u_stop_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .din    (stop_analyzer),
        .rise   (stop_rise)
    );

    sync_rise_detector #(.STAGES(SYNC_STAGES)) u_sig_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .din    (signal_in),
        .rise   (sig_rise)
    );

    // Overflow flags an edge that was lost because the counter was already all-ones.
    always_comb begin
        cnt_next   = live_cnt;
        ovf_next   = live_ovf;
        ticks_next = live_ticks + WINDOW_WIDTH'(1);
        if (sig_rise) begin
            if (&live_cnt) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = live_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            live_cnt     <= '0;
            live_ticks   <= '0;
            live_ovf     <= 1'b0;
            edge_count   <= '0;
            window_ticks <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else if (enable) begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state      <= ST_COUNTING;
                        busy       <= 1'b1;
                        live_cnt   <= '0;
                        live_ticks <= '0;
                        live_ovf   <= 1'b0;
                    end
                end
                ST_COUNTING: begin
                    if (stop_rise) begin
                        edge_count   <= cnt_next;
                        window_ticks <= ticks_next;
                        overflow     <= ovf_next;
                        result_valid <= 1'b1;
                        live_cnt     <= '0;
                        live_ticks   <= '0;
                        live_ovf     <= 1'b0;
                        // A coincident start opens the next window with no dead cycle.
                        if (!start_rise) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (ticks_next == MAX_TICKS) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        live_cnt   <= cnt_next;
                        live_ticks <= ticks_next;
                        live_ovf   <= ovf_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_window_analyzer.sv
// Directed bench: dut_a uses default parameters, dut_b a 4-bit edge counter and a 100-tick timeout.
module tb_frequency_window_analyzer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic start_analyzer = 1'b0;
    logic stop_analyzer = 1'b0;
    logic signal_in = 1'b0;

    logic [31:0] ec_a, wt_a;
    logic        rv_a, ov_a, to_a, busy_a;
    logic [3:0]  ec_b;
    logic [31:0] wt_b;
    logic        rv_b, ov_b, to_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    int          rv_a_n, rv_b_n, to_a_n, to_b_n, to_b_t;
    logic [31:0] a_ec [4];
    logic [31:0] a_wt [4];
    logic        a_ov [4];
    int          a_t  [4];
    logic [3:0]  b_ec [4];
    logic [31:0] b_wt [4];
    logic        b_ov [4];

    always #5 clock = ~clock;

    frequency_window_analyzer dut_a (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .start_analyzer (start_analyzer),
        .stop_analyzer  (stop_analyzer),
        .signal_in      (signal_in),
        .edge_count     (ec_a),
        .window_ticks   (wt_a),
        .result_valid   (rv_a),
        .overflow       (ov_a),
        .timeout        (to_a),
        .busy           (busy_a)
    );

    frequency_window_analyzer #(.COUNT_WIDTH(4), .MAX_WINDOW_TICKS(100)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .start_analyzer (start_analyzer),
        .stop_analyzer  (stop_analyzer),
        .signal_in      (signal_in),
        .edge_count     (ec_b),
        .window_ticks   (wt_b),
        .result_valid   (rv_b),
        .overflow       (ov_b),
        .timeout        (to_b),
        .busy           (busy_b)
    );

    task automatic clr();
        rv_a_n = 0; rv_b_n = 0; to_a_n = 0; to_b_n = 0; to_b_t = -1;
        for (int i = 0; i < 4; i++) begin
            a_ec[i] = '0; a_wt[i] = '0; a_ov[i] = 1'b0; a_t[i] = -1;
            b_ec[i] = '0; b_wt[i] = '0; b_ov[i] = 1'b0;
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, pulses recorded.
    task automatic cyc(input int t);
        @(posedge clock);
        #1;
        if (rv_a === 1'b1) begin
            if (rv_a_n < 4) begin
                a_ec[rv_a_n] = ec_a; a_wt[rv_a_n] = wt_a; a_ov[rv_a_n] = ov_a; a_t[rv_a_n] = t;
            end
            rv_a_n++;
        end
        if (rv_b === 1'b1) begin
            if (rv_b_n < 4) begin
                b_ec[rv_b_n] = ec_b; b_wt[rv_b_n] = wt_b; b_ov[rv_b_n] = ov_b;
            end
            rv_b_n++;
        end
        if (to_a === 1'b1) to_a_n++;
        if (to_b === 1'b1) begin
            to_b_n++;
            to_b_t = t;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b1;
        start_analyzer = 1'b0; stop_analyzer = 1'b0; signal_in = 1'b0;
        for (int i = 0; i < 3; i++) cyc(-1);
        reset = 1'b1;
        clr();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_analyzer = i[0]; stop_analyzer = ~i[0]; signal_in = i[0];
            cyc(i);
        end
        n_checks++; if (ec_a !== 32'd0) begin n_fail++; $display("FAIL reset_edge_count: got %0d want 0", ec_a); end
        n_checks++; if (wt_a !== 32'd0) begin n_fail++; $display("FAIL reset_window_ticks: got %0d want 0", wt_a); end
        n_checks++; if (rv_a !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", rv_a); end
        n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ov_a); end
        n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", to_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        start_analyzer = 1'b0; stop_analyzer = 1'b0; signal_in = 1'b0;
        reset = 1'b1;
        clr();
        for (int t = 0; t < 20; t++) begin
            stop_analyzer = t[1]; signal_in = t[0];
            cyc(t);
        end
        n_checks++; if (rv_a_n !== 0) begin n_fail++; $display("FAIL reset_release_rv: got %0d pulses want 0", rv_a_n); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_single_window();
        do_reset();
        for (int t = 0; t < 1100; t++) begin
            signal_in      = (t % 10) >= 5;
            start_analyzer = (t >= 20 && t < 62);
            stop_analyzer  = (t >= 1020 && t < 1030);
            cyc(t);
            if (t == 500) begin
                n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b want 1", busy_a); end
            end
        end
        n_checks++; if (rv_a_n !== 1) begin n_fail++; $display("FAIL single_rv_count: got %0d want 1", rv_a_n); end
        n_checks++; if (a_t[0] !== 1020) begin n_fail++; $display("FAIL single_rv_latency: got cycle %0d want 1020", a_t[0]); end
        n_checks++; if (ec_a !== 32'd100) begin n_fail++; $display("FAIL single_edge_count: got %0d want 100", ec_a); end
        n_checks++; if (wt_a !== 32'd1000) begin n_fail++; $display("FAIL single_window_ticks: got %0d want 1000", wt_a); end
        n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b want 0", ov_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 0; t < 520; t++) begin
            signal_in      = (t % 10) >= 5;
            start_analyzer = (t >= 10 && t < 50) || (t >= 300 && t < 350);
            stop_analyzer  = (t == 300) || (t == 500);
            cyc(t);
            if (t == 300) begin
                n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_hold: got %b want 1", busy_a); end
            end
        end
        n_checks++; if (rv_a_n !== 2) begin n_fail++; $display("FAIL b2b_rv_count: got %0d want 2", rv_a_n); end
        n_checks++; if (a_wt[0] !== 32'd290) begin n_fail++; $display("FAIL b2b_first_ticks: got %0d want 290", a_wt[0]); end
        n_checks++; if (a_ec[0] !== 32'd29) begin n_fail++; $display("FAIL b2b_first_edges: got %0d want 29", a_ec[0]); end
        n_checks++; if (a_wt[1] !== 32'd200) begin n_fail++; $display("FAIL b2b_second_ticks: got %0d want 200", a_wt[1]); end
        n_checks++; if (a_ec[1] !== 32'd20) begin n_fail++; $display("FAIL b2b_second_edges: got %0d want 20", a_ec[1]); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int t = 0; t < 200; t++) begin
            signal_in      = (t % 10) >= 5;
            start_analyzer = (t >= 5 && t < 21) || (t >= 60 && t < 71);
            stop_analyzer  = (t >= 50 && t < 55);
            cyc(t);
        end
        n_checks++; if (rv_b_n !== 1) begin n_fail++; $display("FAIL timeout_rv_count: got %0d want 1", rv_b_n); end
        n_checks++; if (to_b_n !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", to_b_n); end
        n_checks++; if (to_b_t !== 160) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 160", to_b_t); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy_b); end
        n_checks++; if (ec_b !== 4'd5) begin n_fail++; $display("FAIL timeout_keep_edges: got %0d want 5", ec_b); end
        n_checks++; if (wt_b !== 32'd45) begin n_fail++; $display("FAIL timeout_keep_ticks: got %0d want 45", wt_b); end
        n_checks++; if (to_a_n !== 0) begin n_fail++; $display("FAIL timeout_long_dut_pulses: got %0d want 0", to_a_n); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL timeout_long_dut_busy: got %b want 1", busy_a); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 140; t++) begin
            signal_in      = (t < 91) && ((t % 4) >= 2);
            start_analyzer = (t >= 10 && t < 20) || (t >= 100 && t < 110);
            stop_analyzer  = (t >= 90 && t < 95) || (t >= 130 && t < 135);
            cyc(t);
        end
        n_checks++; if (rv_b_n !== 2) begin n_fail++; $display("FAIL sat_rv_count: got %0d want 2", rv_b_n); end
        n_checks++; if (b_ec[0] !== 4'd15) begin n_fail++; $display("FAIL sat_edge_count: got %0d want 15", b_ec[0]); end
        n_checks++; if (b_ov[0] !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b want 1", b_ov[0]); end
        n_checks++; if (b_wt[0] !== 32'd80) begin n_fail++; $display("FAIL sat_ticks: got %0d want 80", b_wt[0]); end
        n_checks++; if (a_ec[0] !== 32'd20) begin n_fail++; $display("FAIL sat_wide_edges: got %0d want 20", a_ec[0]); end
        n_checks++; if (a_ov[0] !== 1'b0) begin n_fail++; $display("FAIL sat_wide_overflow: got %b want 0", a_ov[0]); end
        n_checks++; if (ec_b !== 4'd0) begin n_fail++; $display("FAIL clean_edge_count: got %0d want 0", ec_b); end
        n_checks++; if (ov_b !== 1'b0) begin n_fail++; $display("FAIL clean_overflow: got %b want 0", ov_b); end
        n_checks++; if (wt_b !== 32'd30) begin n_fail++; $display("FAIL clean_ticks: got %0d want 30", wt_b); end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        for (int t = 0; t < 230; t++) begin
            enable         = !(t >= 100 && t < 150);
            signal_in      = (t >= 30 && t < 35) || (t >= 60 && t < 65) ||
                             (t >= 120 && t < 125) || (t >= 180 && t < 185);
            start_analyzer = (t >= 10 && t < 20);
            stop_analyzer  = (t >= 210 && t < 215);
            cyc(t);
        end
        enable = 1'b1;
        n_checks++; if (rv_a_n !== 1) begin n_fail++; $display("FAIL enable_rv_count: got %0d want 1", rv_a_n); end
        n_checks++; if (ec_a !== 32'd3) begin n_fail++; $display("FAIL enable_edge_count: got %0d want 3", ec_a); end
        n_checks++; if (wt_a !== 32'd150) begin n_fail++; $display("FAIL enable_window_ticks: got %0d want 150", wt_a); end

        clr();
        signal_in = 1'b0;
        for (int t = 0; t < 120; t++) begin
            reset          = !(t >= 50 && t < 53);
            start_analyzer = (t >= 10 && t < 20);
            stop_analyzer  = (t >= 100 && t < 105);
            cyc(t);
            if (t == 40) begin
                n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b want 1", busy_a); end
            end
            if (t == 55) begin
                n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after: got %b want 0", busy_a); end
            end
        end
        reset = 1'b1;
        n_checks++; if (rv_a_n !== 0) begin n_fail++; $display("FAIL midreset_rv: got %0d pulses want 0", rv_a_n); end
        n_checks++; if (ec_a !== 32'd0) begin n_fail++; $display("FAIL midreset_edge_count: got %0d want 0", ec_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_end: got %b want 0", busy_a); end
    endtask

    initial begin
        clr();
        test_reset();
        test_single_window();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_enable_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
